// File: rtl/csa_pkg.sv
// Shared types and constants for the conditional-sum subtractor.
package csa_pkg;

  localparam int CSA_WIDTH = 8;
  localparam int CSA_GROUP = 2;
  localparam int CSA_NGRP  = CSA_WIDTH / CSA_GROUP;

  // Sum and carry of one group for both carry-in assumptions.
  typedef struct packed {
    logic [CSA_GROUP-1:0] sum0;
    logic                 c0;
    logic [CSA_GROUP-1:0] sum1;
    logic                 c1;
  } cond_pair_t;

  // Everything stage 2 needs: 24 conditional bits, the real carry-in
  // and both operand sign bits for the overflow check.
  typedef struct packed {
    cond_pair_t [CSA_NGRP-1:0] grp;
    logic                      cin;
    logic                      x_msb;
    logic                      y_msb;
  } s1_reg_t;

  // Wide NOR used for the zero flag.
  function automatic logic all_zero(input logic [CSA_WIDTH-1:0] v);
    return ~|v;
  endfunction

endpackage

// File: rtl/csa_cond_cell2.sv
// 2-bit conditional-sum cell: two short ripple chains, one assuming
// carry-in 0 and one assuming carry-in 1.
module csa_cond_cell2
  import csa_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output cond_pair_t pair
);

  logic [1:0] sum0;
  logic [1:0] sum1;
  logic       c0_mid;
  logic       c1_mid;
  logic       c0_out;
  logic       c1_out;

  full_adder u_fa0_lo (.a(a[0]), .b(b[0]), .cin(1'b0),   .sum(sum0[0]), .cout(c0_mid));
  full_adder u_fa0_hi (.a(a[1]), .b(b[1]), .cin(c0_mid), .sum(sum0[1]), .cout(c0_out));
  full_adder u_fa1_lo (.a(a[0]), .b(b[0]), .cin(1'b1),   .sum(sum1[0]), .cout(c1_mid));
  full_adder u_fa1_hi (.a(a[1]), .b(b[1]), .cin(c1_mid), .sum(sum1[1]), .cout(c1_out));

  assign pair = '{sum0: sum0, c0: c0_out, sum1: sum1, c1: c1_out};

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplexer_1bit.sv
// Two-way 1-bit multiplexer.
module multiplexer_1bit (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/multiplexer_2bit.sv
// Two-way 2-bit multiplexer.
module multiplexer_2bit (
  input  logic       sel,
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  output logic [1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/multiplexer_4bit.sv
// Two-way 4-bit multiplexer.
module multiplexer_4bit (
  input  logic       sel,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [3:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/csa_subtractor_pipe.sv
// Two-stage conditional-sum subtractor: diff = x - y - bin, computed as
// x + ~y + ~bin with borrow-out = ~carry-out. Valid/ready on both sides.
module csa_subtractor_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH  // only 8 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // ---------------------------------------------------------------- state
  logic                 s1_valid_q, s1_valid_d;
  s1_reg_t              s1_data_q,  s1_data_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [CSA_WIDTH-1:0] diff_q,     diff_d;
  logic                 bout_q,     bout_d;
  logic                 ovf_q,      ovf_d;
  logic                 zero_q,     zero_d;

  // ------------------------------------------------------------ handshake
  logic s1_ready;
  logic s2_ready;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  // ------------------------------------------------- stage 1: group cells
  logic [CSA_WIDTH-1:0]      y_inv;
  cond_pair_t [CSA_NGRP-1:0] cell_pair;

  assign y_inv = ~y;

  for (genvar g = 0; g < CSA_NGRP; g++) begin : g_cell
    csa_cond_cell2 u_cell (
      .a    (x[CSA_GROUP*g +: CSA_GROUP]),
      .b    (y_inv[CSA_GROUP*g +: CSA_GROUP]),
      .pair (cell_pair[g])
    );
  end

  // Stage 1 loads new operands when accepted, clears when drained.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = '{grp: cell_pair, cin: ~bin, x_msb: x[CSA_WIDTH-1],
                      y_msb: y[CSA_WIDTH-1]};
      end
    end
  end

  // ---------------------------------------------- stage 2: merge tree
  // 4-bit merge: index [m][k] = merged half m under carry-in assumption k.
  logic [3:0] m4_sum [2][2];
  logic       m4_c   [2][2];

  for (genvar m = 0; m < 2; m++) begin : g_m4
    for (genvar k = 0; k < 2; k++) begin : g_k
      cond_pair_t lo_pair;
      cond_pair_t hi_pair;
      logic [1:0] lo_sum;
      logic       lo_c;
      logic [1:0] hi_sum;

      assign lo_pair = s1_data_q.grp[2*m];
      assign hi_pair = s1_data_q.grp[2*m+1];
      assign lo_sum  = (k == 0) ? lo_pair.sum0 : lo_pair.sum1;
      assign lo_c    = (k == 0) ? lo_pair.c0   : lo_pair.c1;

      multiplexer_2bit u_hi_sum (.sel(lo_c), .d0(hi_pair.sum0), .d1(hi_pair.sum1), .y(hi_sum));
      multiplexer_1bit u_hi_c   (.sel(lo_c), .d0(hi_pair.c0),   .d1(hi_pair.c1),   .y(m4_c[m][k]));

      assign m4_sum[m][k] = {hi_sum, lo_sum};
    end
  end

  // 8-bit merge under each assumption: upper half chosen by lower carry.
  logic [3:0] s8_hi [2];
  logic       s8_c  [2];

  for (genvar k = 0; k < 2; k++) begin : g_m8
    multiplexer_4bit u_hi8 (.sel(m4_c[0][k]), .d0(m4_sum[1][0]), .d1(m4_sum[1][1]), .y(s8_hi[k]));
    multiplexer_1bit u_c8  (.sel(m4_c[0][k]), .d0(m4_c[1][0]),   .d1(m4_c[1][1]),   .y(s8_c[k]));
  end

  // Final select by the real carry-in.
  logic [CSA_WIDTH-1:0] diff_sel;
  logic                 cout_sel;

  multiplexer_4bit u_sel_lo (.sel(s1_data_q.cin), .d0(m4_sum[0][0]), .d1(m4_sum[0][1]), .y(diff_sel[3:0]));
  multiplexer_4bit u_sel_hi (.sel(s1_data_q.cin), .d0(s8_hi[0]),     .d1(s8_hi[1]),     .y(diff_sel[7:4]));
  multiplexer_1bit u_sel_c  (.sel(s1_data_q.cin), .d0(s8_c[0]),      .d1(s8_c[1]),      .y(cout_sel));

  // Stage 2 captures the selected result and flags when stage 1 hands over.
  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = diff_sel;
        bout_d = ~cout_sel;
        ovf_d  = (s1_data_q.x_msb != s1_data_q.y_msb) &&
                 (diff_sel[CSA_WIDTH-1] != s1_data_q.x_msb);
        zero_d = all_zero(diff_sel);
      end
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath flops are reset too, since the result outputs have
      // defined reset values that a consumer can observe.
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge
      // values regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/csa_subtractor_pipe.md
# csa_subtractor_pipe

Pipelined 8-bit conditional-sum subtractor computing `diff = x - y - bin` with borrow-out, signed-overflow and zero flags. It is the arithmetic inverse of the team's conditional-sum adder and reuses the same conditional-sum cells, operating on `~y` with carry-in `~bin`. It sits between an operand producer and a result consumer, uses valid/ready handshakes on both sides, sustains one operation per cycle, and has a fixed 2-cycle latency.

## Interface
- `WIDTH`, 8: operand width; only 8 is supported (4 two-bit groups → 2 four-bit → 1 eight-bit merge).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands this cycle.
- `x`  in  8  minuend.
- `y`  in  8  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result this cycle.
- `diff`  out  8  `(x - y - bin) mod 256`.
- `bout`  out  1  borrow-out; 1 when unsigned `x < y + bin`.
- `ovf`  out  1  signed (two's-complement) overflow.
- `zero`  out  1  `diff == 0`.

## Operation
- Internal identity: `diff = x + ~y + cin`, where `cin = ~bin` and `bout = ~cout`.
- Stage 1 (S1): for each 2-bit group g0..g3, compute the sum and carry for both assumptions, cin=0 and cin=1. Register all 24 conditional bits, plus `cin`, `x[7]` and `y[7]`, and set `s1_valid`.
- Stage 2 (S2): merge groups into 4-bit conditional pairs (g1 selected by the g0 carry, g3 by the g2 carry). Merge into 8-bit, then select by `cin`. Register `diff`, `bout`, `ovf` and `zero`, and set `s2_valid`.
- `ovf = (x[7] != y[7]) && (diff[7] != x[7])`, evaluated in S2 from the registered sign bits.
- `zero` is computed from the final selected `diff`. It is independent of `bout`.
- Handshake:
  - `s2_ready = !s2_valid || out_ready`
  - `s1_ready = !s1_valid || s2_ready`
  - `in_ready = s1_ready` (combinational)
- Transfers:
  - An input transfer occurs on `in_valid && in_ready`.
  - An output transfer occurs on `out_valid && out_ready`.
  - Each stage loads when its upstream stage is valid and the stage itself is ready.
  - A stage that loads no new data but is drained clears its valid.
- Stability: while `out_valid && !out_ready`, `diff`, `bout`, `ovf` and `zero` hold stable.
- Order: results leave in acceptance order; there is no reordering or dropping.
- Full: with both stages valid and `out_ready=0`, `in_ready=0`.
- Simultaneous events: when full, a cycle with `out_ready=1` lets all three transfers (in→S1, S1→S2, S2→out) occur in the same cycle.
- Empty: `out_valid=0`. The data outputs keep their last value and are don't-care.

## Timing
- Reset values (asynchronous, immediate):
  - `s1_valid=0`, `s2_valid=0`, so `out_valid=0` and `in_ready=1`.
  - `diff=0`, `bout=0`, `ovf=0`, `zero=0`.
  - All S1 conditional registers = 0.
- Reset mid-operation: in-flight operations are discarded and produce no output. Operation resumes on the first `clk` edge after `rst` deasserts.
- Latency: an operation accepted at edge N has `out_valid=1` after edge N+1 and is presented until accepted. With `out_ready` held high, it is consumed at edge N+2.
- Throughput: 1 operation/cycle with `out_ready` held high.
- Combinational depth:
  - S1: one 2-bit ripple.
  - S2: two mux levels plus the final select and an 8-input NOR.
  - No input-to-output combinational path except `out_ready`→`in_ready`.

## Structure
- Package `csa_pkg`:
  - `CSA_WIDTH=8`, `CSA_GROUP=2`.
  - Typedef `cond_pair_t` {sum0, c0, sum1, c1} parameterized by group width.
  - Typedef `s1_reg_t` for the S1 payload.
- Sub-module `csa_cond_cell2`: a 2-bit conditional-sum cell built from the existing `full_adder`, outputting a `cond_pair_t`. It is instantiated 4× in S1.
- Merge muxes use the existing `multiplexer_1bit`, `multiplexer_2bit` and `multiplexer_4bit` modules.

## Test plan
- x=0x50, y=0x30, bin=0 → diff=0x20, bout=0, ovf=0, zero=0; out_valid appears 1 cycle after acceptance.
- x=0x00, y=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then x=0x10, y=0x0F, bin=1 → diff=0x00, zero=1, bout=0.
- x=0x80, y=0x01 → diff=0x7F, ovf=1, bout=0. Then x=0x7F, y=0xFF → diff=0x80, ovf=1, bout=1.
- Backpressure: issue 3 back-to-back ops with out_ready=0 → two are accepted, in_ready=0 on the third cycle, and outputs hold the first result stable. Raise out_ready → 3 results arrive in order, and the third op is accepted in the release cycle.
- Streaming: 256 random ops with in_valid and out_ready held at 1 → one result per cycle, all matching the reference model `{~bout, diff} = x + ~y + ~bin`.
- Assert rst asynchronously with both stages full → out_valid=0, diff=0 and in_ready=1 immediately (no clock edge needed). No stale result appears after release; the next accepted op returns correctly 2 edges later.
